// File: rtl/stoch_decode_pkg.sv
// Shared types and helpers for the stochastic-to-binary decoder matrix.
package stoch_decode_pkg;

   // Decoder control states: waiting for START, or accumulating a window.
   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } state_t;

   // Width of a signed per-element result: counts reach N = 2^window_log2,
   // so the difference spans -N..+N and needs window_log2+2 bits.
   function automatic int res_width(input int window_log2);
      return window_log2 + 2;
   endfunction

endpackage

// File: rtl/stoch_decode.sv
// Single-element decoder: counts ones on the positive and negative
// bitstreams and presents their signed difference, including the bits
// of the current cycle so the owner can capture a full window on the
// same edge that completes it.
module stoch_decode
   import stoch_decode_pkg::*;
#(
   parameter int WINDOW_LOG2 = 8,
   localparam int RW = res_width(WINDOW_LOG2)
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          en,
   input  logic          clr,
   input  logic          a_p,
   input  logic          a_n,
   output logic [RW-1:0] diff
);

   localparam int CW = WINDOW_LOG2 + 1;

   logic [CW-1:0] cnt_p;
   logic [CW-1:0] cnt_n;
   logic [RW-1:0] sum_p;
   logic [RW-1:0] sum_n;

   // Ones counters; clear takes priority so a completing sample is not
   // carried into the next window.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_p <= '0;
         cnt_n <= '0;
      end else if (clr) begin
         cnt_p <= '0;
         cnt_n <= '0;
      end else if (en) begin
         cnt_p <= cnt_p + CW'(a_p);
         cnt_n <= cnt_n + CW'(a_n);
      end
   end

   // Signed difference of the totals including this cycle's bits.
   always_comb begin
      sum_p = {1'b0, cnt_p} + RW'(a_p);
      sum_n = {1'b0, cnt_n} + RW'(a_n);
      diff  = sum_p - sum_n;
   end

endmodule

// File: rtl/stoch_decode_mat.sv
// Matrix of stochastic decoders sharing one window sample counter.
// Owns the IDLE/ACCUM control, the result register and the readout
// handshake.
module stoch_decode_mat
   import stoch_decode_pkg::*;
#(
   parameter int NUM_ROWS    = 2,
   parameter int NUM_COLS    = 2,
   parameter int WINDOW_LOG2 = 8
) (
   input  logic                                                CLK,
   input  logic                                                RST,
   input  logic                                                START,
   input  logic                                                CONT,
   input  logic                                                EN,
   input  logic [NUM_ROWS-1:0][NUM_COLS-1:0]                   A_P,
   input  logic [NUM_ROWS-1:0][NUM_COLS-1:0]                   A_N,
   output logic [NUM_ROWS-1:0][NUM_COLS-1:0][WINDOW_LOG2+1:0]  Y,
   output logic                                                Y_VALID,
   input  logic                                                Y_READY,
   output logic                                                BUSY,
   output logic                                                OVERRUN
);

   localparam int RW = res_width(WINDOW_LOG2);
   localparam logic [WINDOW_LOG2-1:0] LAST = '1;

   state_t                    state;
   state_t                    state_nx;
   logic [WINDOW_LOG2-1:0]    scnt;
   logic                      cnt_en;
   logic                      cnt_clr;
   logic                      complete;
   logic [NUM_ROWS-1:0][NUM_COLS-1:0][RW-1:0] diff;

   // Control state register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= IDLE;
      else     state <= state_nx;
   end

   // Next state: START leaves IDLE; a completing window returns to IDLE
   // unless continuous mode is requested at that moment.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (START) state_nx = ACCUM;
         ACCUM:   if (complete && !CONT) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Control outputs; counters are held clear throughout IDLE so every
   // window starts from zero.
   always_comb begin
      cnt_en   = (state == ACCUM) && EN;
      complete = cnt_en && (scnt == LAST);
      cnt_clr  = (state == IDLE) || complete;
      BUSY     = (state == ACCUM);
   end

   // Shared sample counter keeps all element windows aligned.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)          scnt <= '0;
      else if (cnt_clr) scnt <= '0;
      else if (cnt_en)  scnt <= scnt + 1'b1;
   end

   for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
      for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
         stoch_decode #(
            .WINDOW_LOG2 (WINDOW_LOG2)
         ) u_elem (
            .CLK  (CLK),
            .RST  (RST),
            .en   (cnt_en),
            .clr  (cnt_clr),
            .a_p  (A_P[r][c]),
            .a_n  (A_N[r][c]),
            .diff (diff[r][c])
         );
      end
   end

   // Readout handshake: Y is offered while Y_VALID=1 and is consumed on
   // any edge with Y_VALID & Y_READY; Y holds steady until then. A window
   // completing on the same edge reloads Y and keeps Y_VALID high; if the
   // old result was not being consumed at that edge it is lost and
   // OVERRUN latches until reset.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         Y       <= '0;
         Y_VALID <= 1'b0;
         OVERRUN <= 1'b0;
      end else if (complete) begin
         Y       <= diff;
         Y_VALID <= 1'b1;
         if (Y_VALID && !Y_READY) OVERRUN <= 1'b1;
      end else if (Y_VALID && Y_READY) begin
         Y_VALID <= 1'b0;
      end
   end

endmodule

// File: tb/tb_stoch_decode_mat.sv
// Bench for stoch_decode_mat with a 2x2 matrix and 8-sample windows.
module tb_stoch_decode_mat;

   localparam int R  = 2;
   localparam int C  = 2;
   localparam int WL = 3;
   localparam int N  = 8;

   // ---------------- clock / reset / DUT ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0;
   logic cont = 1'b0;
   logic en = 1'b0;
   logic y_ready = 1'b0;
   logic [R-1:0][C-1:0] a_p = '0;
   logic [R-1:0][C-1:0] a_n = '0;
   logic [R-1:0][C-1:0][WL+1:0] y;
   logic y_valid;
   logic busy;
   logic overrun;
   logic chk_en = 1'b0;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   stoch_decode_mat #(
      .NUM_ROWS    (R),
      .NUM_COLS    (C),
      .WINDOW_LOG2 (WL)
   ) dut (
      .CLK     (clk),
      .RST     (rst),
      .START   (start),
      .CONT    (cont),
      .EN      (en),
      .A_P     (a_p),
      .A_N     (a_n),
      .Y       (y),
      .Y_VALID (y_valid),
      .Y_READY (y_ready),
      .BUSY    (busy),
      .OVERRUN (overrun)
   );

   // ---------------- behavioural model ----------------
   // Window-level view: running sums of counted ones, a count of counted
   // samples, and the last published result with its status flags.
   bit m_run = 1'b0;
   bit m_valid = 1'b0;
   bit m_over = 1'b0;
   int m_cnt = 0;
   int sp[R][C];
   int sn[R][C];
   int m_y[R][C];

   task automatic model_clear_sums();
      for (int i = 0; i < R; i++)
         for (int j = 0; j < C; j++) begin
            sp[i][j] = 0;
            sn[i][j] = 0;
         end
      m_cnt = 0;
   endtask

   initial begin
      model_clear_sums();
      for (int i = 0; i < R; i++)
         for (int j = 0; j < C; j++) m_y[i][j] = 0;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_run = 0;
            m_valid = 0;
            m_over = 0;
            model_clear_sums();
            for (int i = 0; i < R; i++)
               for (int j = 0; j < C; j++) m_y[i][j] = 0;
         end else begin
            bit done;
            done = 0;
            if (!m_run) begin
               if (start) begin
                  m_run = 1;
                  model_clear_sums();
               end
            end else if (en) begin
               for (int i = 0; i < R; i++)
                  for (int j = 0; j < C; j++) begin
                     sp[i][j] += int'(a_p[i][j]);
                     sn[i][j] += int'(a_n[i][j]);
                  end
               m_cnt++;
               if (m_cnt == N) begin
                  done = 1;
                  for (int i = 0; i < R; i++)
                     for (int j = 0; j < C; j++) m_y[i][j] = sp[i][j] - sn[i][j];
                  if (m_valid && !y_ready) m_over = 1;
                  m_valid = 1;
                  model_clear_sums();
                  if (!cont) m_run = 0;
               end
            end
            if (!done && m_valid && y_ready) m_valid = 0;
         end
      end
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic signed [31:0] act,
                        input logic signed [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of the DUT against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en && !rst) begin
            check("busy", busy, m_run);
            check("y_valid", y_valid, m_valid);
            check("overrun", overrun, m_over);
            if (m_valid)
               for (int i = 0; i < R; i++)
                  for (int j = 0; j < C; j++)
                     check($sformatf("y[%0d][%0d]", i, j), $signed(y[i][j]), m_y[i][j]);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input logic s, input logic c, input logic e, input logic r,
                        input logic [3:0] ap, input logic [3:0] an);
      @(negedge clk);
      start   = s;
      cont    = c;
      en      = e;
      y_ready = r;
      a_p     = ap;
      a_n     = an;
   endtask

   // Async reset asserted between clock edges; outputs must clear at once.
   task automatic async_reset(input string tag);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check({tag, "_y"}, y, 0);
      check({tag, "_valid"}, y_valid, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_over"}, overrun, 0);
      @(negedge clk);
      rst = 1'b0;
      start = 1'b0; cont = 1'b0; en = 1'b0; y_ready = 1'b0; a_p = '0; a_n = '0;
   endtask

   // ---------------- stimulus ----------------
   bit ep[10]   = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1};
   bit ap00[10] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
   bit an00[10] = '{0, 1, 0, 0, 1, 0, 0, 1, 0, 0};

   initial begin
      #3 rst = 1'b1;
      #10;
      @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;

      // Inputs wiggling in IDLE without START change nothing.
      for (int k = 0; k < 6; k++)
         drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      drive(0, 0, 0, 0, 0, 0);
      check("idle_y", y, 0);
      check("idle_valid", y_valid, 0);
      check("idle_busy", busy, 0);

      // Extremes: +8, -8 and two cancelling elements.
      drive(1, 0, 0, 0, 0, 0);
      for (int k = 0; k < N; k++) begin
         drive(0, 0, 1, 0, 4'b0111, 4'b1110);
         if (k == N - 1) begin
            check("ext_busy_before", busy, 1);
            check("ext_valid_before", y_valid, 0);
         end
      end
      drive(0, 0, 0, 0, 0, 0);
      check("ext_y00", $signed(y[0][0]), 8);
      check("ext_y11", $signed(y[1][1]), -8);
      check("ext_y01", $signed(y[0][1]), 0);
      check("ext_y10", $signed(y[1][0]), 0);
      check("ext_valid", y_valid, 1);
      check("ext_busy", busy, 0);
      check("model_ext_y11", m_y[1][1], -8);
      drive(0, 0, 0, 1, 0, 0);
      drive(0, 0, 0, 0, 0, 0);
      check("ext_consumed", y_valid, 0);

      // EN gaps: ones during EN=0 must not count.
      drive(1, 0, 0, 0, 0, 0);
      for (int k = 0; k < 10; k++)
         drive(0, 0, ep[k], 0,
               {3'($urandom_range(0, 7)), ap00[k]}, {3'($urandom_range(0, 7)), an00[k]});
      drive(0, 0, 0, 0, 0, 0);
      check("gap_y00", $signed(y[0][0]), 4);
      check("gap_valid", y_valid, 1);
      check("model_gap_y00", m_y[0][0], 4);
      drive(0, 0, 0, 1, 0, 0);
      drive(0, 0, 0, 0, 0, 0);

      // Continuous windows under backpressure.
      drive(1, 1, 0, 0, 0, 0);
      for (int k = 0; k < N; k++) drive(0, 1, 1, 0, 4'b0001, 4'b0000);
      drive(0, 1, 1, 0, 0, 0);
      check("cont_w1_y00", $signed(y[0][0]), 8);
      check("cont_w1_over", overrun, 0);
      for (int k = 1; k < N; k++) drive(0, 1, 1, 0, 0, 0);
      drive(0, 1, 0, 0, 0, 0);
      check("cont_w2_y00", $signed(y[0][0]), 0);
      check("cont_w2_valid", y_valid, 1);
      check("cont_w2_over", overrun, 1);
      check("cont_w2_busy", busy, 1);
      drive(0, 1, 0, 1, 0, 0);
      drive(0, 1, 0, 0, 0, 0);
      check("cont_acc_valid", y_valid, 0);
      check("cont_acc_over", overrun, 1);

      // Accept on the very edge a new window completes.
      async_reset("rst1");
      drive(1, 1, 0, 0, 0, 0);
      for (int k = 0; k < N; k++)
         drive(0, 1, 1, 0, {3'($urandom_range(0, 7)), 1'b0}, 4'($urandom_range(0, 15)));
      for (int k = 0; k < N; k++) drive(0, 1, 1, (k == N - 1), 4'b0001, 4'b0000);
      drive(0, 1, 0, 0, 0, 0);
      check("sim_y00", $signed(y[0][0]), 8);
      check("sim_valid", y_valid, 1);
      check("sim_over", overrun, 0);

      // Reset mid-window discards partial counts.
      async_reset("rst2");
      drive(1, 0, 0, 0, 0, 0);
      for (int k = 0; k < 5; k++) drive(0, 0, 1, 0, 4'b0001, 4'b0000);
      async_reset("rst3");
      drive(1, 0, 0, 0, 0, 0);
      for (int k = 0; k < N; k++) drive(0, 0, 1, 0, 4'b0001, 4'b0000);
      drive(0, 0, 0, 0, 0, 0);
      check("abort_y00", $signed(y[0][0]), 8);
      check("abort_valid", y_valid, 1);

      // Random traffic against the model.
      async_reset("rst4");
      for (int k = 0; k < 800; k++)
         drive(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      drive(0, 0, 0, 0, 0, 0);
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   // Guard against a stalled run.
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

endmodule

// File: doc/stoch_decode_mat.md
Name: stoch_decode_mat

Overview:
- Matrix of stochastic-to-binary decoders, the receiving end of the stochastic matrix datapath.
- Consumes NUM_ROWS x NUM_COLS signed bitstream pairs (positive and negative channel) after decorrelation and stochastic arithmetic.
- Counts ones over a window of 2^WINDOW_LOG2 valid cycles and presents a signed binary estimate per element.
- Output uses a valid/ready handshake for the host readout or fixed-point pipeline.

Parameters:
- NUM_ROWS, 2, matrix rows.
- NUM_COLS, 2, matrix columns.
- WINDOW_LOG2, 8, log2 of window length in EN-qualified samples; window N = 2^WINDOW_LOG2.

Ports:
- CLK  input  1  clock.
- RST  input  1  reset; asynchronous, active-high.
- START  input  1  one-cycle pulse; begins decoding from IDLE.
- CONT  input  1  1 = continuous back-to-back windows; 0 = single window then IDLE.
- EN  input  1  sample qualifier; A_P/A_N counted only when EN=1.
- A_P  input  [NUM_ROWS-1:0][NUM_COLS-1:0]  positive-channel bitstreams.
- A_N  input  [NUM_ROWS-1:0][NUM_COLS-1:0]  negative-channel bitstreams.
- Y  output  [NUM_ROWS-1:0][NUM_COLS-1:0][WINDOW_LOG2+1:0]  signed two's-complement estimate; value = Y/N.
- Y_VALID  output  1  Y holds an unconsumed result.
- Y_READY  input  1  consumer accepts Y when Y_VALID & Y_READY.
- BUSY  output  1  FSM in ACCUM.
- OVERRUN  output  1  sticky; a completed window overwrote an unconsumed result.

Behaviour:
- Reset (async, RST=1): FSM=IDLE; sample counter, all element counters, Y, Y_VALID, BUSY and OVERRUN all 0.
- FSM states:
  - IDLE: START=1 -> ACCUM. Counters cleared on entry. EN and inputs ignored in IDLE, including the START cycle.
  - ACCUM: each cycle with EN=1, sample counter +1; per element, cnt_p += A_P and cnt_n += A_N. Counters are WINDOW_LOG2+1 bits unsigned, so 0..N never wraps.
  - Window completion: the EN=1 cycle where sample counter = N-1. On that edge:
    - Y[i][j] <= cnt_p + A_P - (cnt_n + A_N), sign-extended to WINDOW_LOG2+2 bits; range -N..+N.
    - Y_VALID <= 1; all counters <= 0.
    - CONT=1: stay in ACCUM; the next window's first sample may arrive the following cycle (no gap).
    - CONT=0: -> IDLE.
  - Latency: Y/Y_VALID visible the cycle after the Nth EN sample.
- START while in ACCUM: ignored.
- CONT is sampled only at window completion.
- Handshake:
  - Y_VALID & Y_READY at an edge with no completion: Y_VALID <= 0.
  - Y stable while Y_VALID=1 and not accepted, except on overrun.
  - Completion with Y_VALID=1 and Y_READY=1 in the same cycle: old result is consumed, new Y loaded, Y_VALID stays 1, no OVERRUN.
  - Completion with Y_VALID=1 and Y_READY=0: new Y overwrites old, Y_VALID stays 1, OVERRUN <= 1.
  - OVERRUN clears only on RST.
- Y_READY without Y_VALID: no effect.
- BUSY = (state == ACCUM), registered.
- RST mid-window: partial counts discarded, return to IDLE, no output produced.
- EN=0 cycles in ACCUM: no state change except handshake.
- All elements share one sample counter; windows are aligned across the matrix.

Decomposition:
- Package stoch_decode_pkg:
  - FSM state enum {IDLE, ACCUM}.
  - Function giving the result width (WINDOW_LOG2+2).
- Sub-module stoch_decode (single element), instantiated in a row/col generate loop:
  - Inputs: CLK, RST, en, clr, a_p, a_n.
  - Output: signed diff combinational from the counter plus the current-cycle bits.
  - Holds cnt_p and cnt_n.
- The matrix top owns the FSM, the sample counter, the output register and the handshake.

Test Plan (NUM_ROWS=2, NUM_COLS=2, WINDOW_LOG2=3, N=8):
- Reset: assert RST asynchronously mid-cycle -> Y=0, Y_VALID=0, BUSY=0, OVERRUN=0 immediately. Inputs toggling in IDLE without START -> outputs unchanged.
- Basic extremes: START, CONT=0, EN=1 for 8 cycles, A_P[0][0]=1, A_N[0][0]=0, A_P[1][1]=0, A_N[1][1]=1, others A_P=A_N=1:
  - Y[0][0]=+8, Y[1][1]=-8, Y[0][1]=Y[1][0]=0.
  - Y_VALID rises the cycle after the 8th sample; BUSY falls the same cycle.
- EN gaps and mixed density: EN pattern 1,0,1,1,0,1,1,1,1,1. A_P[0][0]=1 on the 5 counted cycles with EN=1 in positions 1,3,4,6,7 and 0 otherwise; A_N[0][0]=1 on 1 counted cycle.
  - Completion after the 8th EN=1 cycle; Y[0][0]=+4.
  - Ones presented during EN=0 cycles are not counted.
- Continuous with backpressure: CONT=1, EN=1 constantly, Y_READY=0, A_P[0][0]=1 for 8 cycles then 0 with A_N=0:
  - Window 1 gives Y[0][0]=8.
  - Window 2 gives Y[0][0]=0 with OVERRUN=1 and Y_VALID held.
  - Assert Y_READY one cycle -> Y_VALID=0; OVERRUN stays 1.
- Simultaneous accept and completion: CONT=1, Y_READY=1 exactly on the completion edge of window 2 -> Y updates, Y_VALID stays 1, OVERRUN stays 0.
- RST mid-window: after 5 samples assert RST, release, START, run 8 samples of A_P[0][0]=1 -> Y[0][0]=+8 (no carry-over from the aborted window).
